// File: rtl/uart_pkg.sv
// Shared types, sample indices and baud divider math for the oversampled UART receiver.
// No logic; latency and backpressure do not apply.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] S_VOTE0    = 4'd7;
    localparam logic [3:0] S_VOTE1    = 4'd8;
    localparam logic [3:0] S_DECIDE   = 4'd9;
    localparam logic [3:0] S_LAST     = 4'd15;

    // Rounded clocks per oversample tick, never below one.
    function automatic int uart_div(input int clk_freq, input int baud, input int os);
        int d;
        d = (clk_freq + (baud * os) / 2) / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Byte hand-off and status bundle from the receiver to the fabric.
// Valid/ready: the master holds rx_data until rx_valid && rx_ready.
interface uart_rx_oversampled_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    modport master (output rx_data, rx_valid, rx_busy, frame_err, overrun, input rx_ready);
    modport slave  (input rx_data, rx_valid, rx_busy, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_os_tick_gen.sv
// One-cycle tick every DIV clocks; clr restarts the period so the next tick is DIV clocks out.
// No backpressure; free running.
module uart_os_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 receiver, 16x oversampled with 3-sample majority; byte valid 1 clk after the stop decision.
// Backpressure: a byte completing while rx_valid && !rx_ready is dropped and overrun pulses.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    uart_rx_oversampled_if.master  bus
);
    localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);

    rx_state_t  state, state_nxt;
    logic       sync1, rx_s;
    logic       tick;
    logic [3:0] s;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       v7, v8;
    logic       maj, decide, bit_end, start_det;
    logic       busy, byte_ok, stop_bad, shift_en;
    logic [7:0] data_q;
    logic       valid_q, fe_q, ov_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    uart_os_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_det),
        .tick (tick)
    );

    assign start_det = (state == IDLE) && !rx_s;
    assign decide    = tick && (s == S_DECIDE);
    assign bit_end   = tick && (s == S_LAST);
    assign maj       = (v7 & v8) | (v7 & rx_s) | (v8 & rx_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx_s) state_nxt = START;
            START:     if (decide && maj) state_nxt = IDLE;
                       else if (bit_end)  state_nxt = DATA;
            DATA:      if (bit_end && bit_cnt == 3'd7) state_nxt = STOP;
            STOP:      if (decide) state_nxt = maj ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        shift_en = (state == DATA) && decide;
        byte_ok  = (state == STOP) && decide && maj;
        stop_bad = (state == STOP) && decide && !maj;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s         <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            v7        <= 1'b0;
            v8        <= 1'b0;
        end else begin
            if (start_det) begin
                s       <= '0;
                bit_cnt <= '0;
            end else if (tick) begin
                s <= s + 4'd1;
                if (state == DATA && s == S_LAST) bit_cnt <= bit_cnt + 3'd1;
            end
            if (tick && s == S_VOTE0) v7 <= rx_s;
            if (tick && s == S_VOTE1) v8 <= rx_s;
            if (shift_en) shift_reg <= {maj, shift_reg[7:1]};
        end
    end

    // A completing byte may replace the held one only if it is consumed this same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            fe_q <= stop_bad;
            ov_q <= byte_ok && valid_q && !bus.rx_ready;
            if (byte_ok && (!valid_q || bus.rx_ready)) begin
                data_q  <= shift_reg;
                valid_q <= 1'b1;
            end else if (valid_q && bus.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.rx_busy   = busy;
    assign bus.frame_err = fe_q;
    assign bus.overrun   = ov_q;
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled at DIV=10 (160 clk per bit).
module tb_uart_rx_oversampled;
    localparam int BIT = 160;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    int   total = 0;
    int   bad   = 0;
    int   acc_cnt = 0;
    int   fe_cnt  = 0;
    int   ov_cnt  = 0;
    logic [7:0] acc_data = 8'h00;

    uart_rx_oversampled_if bus();

    uart_rx_oversampled #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rx_valid && bus.rx_ready) begin
            acc_cnt  <= acc_cnt + 1;
            acc_data <= bus.rx_data;
        end
        if (bus.frame_err) fe_cnt <= fe_cnt + 1;
        if (bus.overrun)   ov_cnt <= ov_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] b);
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(BIT);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_head(b);
        rx = 1'b1;
        wait_clk(BIT);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rx = 1'b1;
        bus.rx_ready = 1'b1;
        wait_clk(3);
        total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.rx_data); end
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.rx_valid); end
        total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.rx_busy); end
        total++; if ({bus.frame_err, bus.overrun} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {bus.frame_err, bus.overrun}); end
        rst = 1'b1;
        wait_clk(20);
    endtask

    task automatic test_basic_byte;
        int c0;
        c0 = acc_cnt;
        send_head(8'hA5);
        rx = 1'b1;
        wait_clk(90);
        total++; if (bus.rx_busy !== 1'b1) begin bad++; $display("FAIL a5_busy_before_decision got=%b want=1", bus.rx_busy); end
        wait_clk(40);
        total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL a5_busy_mid_stop got=%b want=0", bus.rx_busy); end
        total++; if (acc_cnt !== c0 + 1) begin bad++; $display("FAIL a5_count got=%0d want=%0d", acc_cnt, c0 + 1); end
        total++; if (acc_data !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h want=a5", acc_data); end
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL a5_valid_dropped got=%b want=0", bus.rx_valid); end
        total++; if (fe_cnt !== 0 || ov_cnt !== 0) begin bad++; $display("FAIL a5_flags got fe=%0d ov=%0d want 0 0", fe_cnt, ov_cnt); end
        wait_clk(30);
    endtask

    task automatic test_false_start;
        int c0, f0;
        c0 = acc_cnt; f0 = fe_cnt;
        rx = 1'b0;
        wait_clk(60);
        rx = 1'b1;
        wait_clk(140);
        total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL false_start_busy got=%b want=0", bus.rx_busy); end
        total++; if (acc_cnt !== c0 || bus.rx_valid !== 1'b0) begin bad++; $display("FAIL false_start_valid got cnt=%0d valid=%b want cnt=%0d valid=0", acc_cnt, bus.rx_valid, c0); end
        total++; if (fe_cnt !== f0) begin bad++; $display("FAIL false_start_fe got=%0d want=%0d", fe_cnt, f0); end
        wait_clk(50);
    endtask

    task automatic test_frame_error;
        int c0, f0;
        c0 = acc_cnt; f0 = fe_cnt;
        send_head(8'h3C);
        rx = 1'b0;
        wait_clk(BIT + 500);
        total++; if (fe_cnt !== f0 + 1) begin bad++; $display("FAIL fe_pulse_count got=%0d want=%0d", fe_cnt, f0 + 1); end
        total++; if (acc_cnt !== c0) begin bad++; $display("FAIL fe_no_valid got=%0d want=%0d", acc_cnt, c0); end
        total++; if (bus.rx_busy !== 1'b1) begin bad++; $display("FAIL fe_wait_high_busy got=%b want=1", bus.rx_busy); end
        rx = 1'b1;
        wait_clk(20);
        total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL fe_back_idle got=%b want=0", bus.rx_busy); end
        send_byte(8'h55);
        total++; if (acc_cnt !== c0 + 1 || acc_data !== 8'h55) begin bad++; $display("FAIL fe_next_byte got cnt=%0d data=%h want cnt=%0d data=55", acc_cnt, acc_data, c0 + 1); end
        total++; if (fe_cnt !== f0 + 1) begin bad++; $display("FAIL fe_single_pulse got=%0d want=%0d", fe_cnt, f0 + 1); end
    endtask

    task automatic test_overrun;
        int c0, o0;
        c0 = acc_cnt; o0 = ov_cnt;
        bus.rx_ready = 1'b0;
        send_byte(8'h11);
        send_head(8'h22);
        rx = 1'b1;
        wait_clk(130);
        total++; if (bus.rx_valid !== 1'b1) begin bad++; $display("FAIL ov_valid got=%b want=1", bus.rx_valid); end
        total++; if (bus.rx_data !== 8'h11) begin bad++; $display("FAIL ov_data_held got=%h want=11", bus.rx_data); end
        total++; if (ov_cnt !== o0 + 1) begin bad++; $display("FAIL ov_pulse got=%0d want=%0d", ov_cnt, o0 + 1); end
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        wait_clk(2);
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL ov_valid_after_consume got=%b want=0", bus.rx_valid); end
        total++; if (acc_cnt !== c0 + 1 || acc_data !== 8'h11) begin bad++; $display("FAIL ov_consumed got cnt=%0d data=%h want cnt=%0d data=11", acc_cnt, acc_data, c0 + 1); end
        bus.rx_ready = 1'b1;
        wait_clk(40);
    endtask

    task automatic test_glitch;
        logic [7:0] b;
        b = 8'h81;
        rx = 1'b0;
        wait_clk(BIT);
        rx = 1'b1;
        wait_clk(90);
        rx = 1'b0;
        wait_clk(1);
        rx = 1'b1;
        wait_clk(BIT - 91);
        for (int i = 1; i < 8; i++) begin
            rx = b[i];
            wait_clk(BIT);
        end
        rx = 1'b1;
        wait_clk(BIT);
        total++; if (acc_data !== 8'h81) begin bad++; $display("FAIL glitch_data got=%h want=81", acc_data); end
        total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b want=0", bus.rx_busy); end
    endtask

    task automatic test_reset_mid_frame;
        int c0;
        rx = 1'b0;
        wait_clk(BIT + 3 * BIT + 80);
        total++; if (bus.rx_busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_before got=%b want=1", bus.rx_busy); end
        rst = 1'b0;
        #1;
        total++; if ({bus.rx_valid, bus.rx_busy, bus.frame_err, bus.overrun} !== 4'b0000) begin bad++; $display("FAIL rst_mid_outputs got=%b want=0000", {bus.rx_valid, bus.rx_busy, bus.frame_err, bus.overrun}); end
        total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_data got=%h want=00", bus.rx_data); end
        rx = 1'b1;
        wait_clk(5);
        rst = 1'b1;
        wait_clk(20);
        c0 = acc_cnt;
        send_byte(8'h0F);
        total++; if (acc_cnt !== c0 + 1 || acc_data !== 8'h0F) begin bad++; $display("FAIL rst_fresh_byte got cnt=%0d data=%h want cnt=%0d data=0f", acc_cnt, acc_data, c0 + 1); end
    endtask

    initial begin
        test_reset();
        test_basic_byte();
        test_false_start();
        test_frame_error();
        test_overrun();
        test_glitch();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
Standalone 8N1 UART receiver for an external, asynchronous serial pin. It is the receiving end of the existing 8N1 transmitter when the link leaves the chip rather than looping back internally. It uses 16x oversampling with majority voting, rejects false start bits, detects framing errors, and hands bytes to the fabric over a valid/ready interface with overrun reporting.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUD, 115200, line bit rate.
OVERSAMPLE, 16, samples per bit. Fixed at 16; any other value is unsupported.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous active-low reset: asserted when 0, released synchronously to clk.
rx  input  1  serial line, asynchronous to clk, idles high.
rx_data  output  8  received byte, LSB first on the line.
rx_valid  output  1  rx_data holds an unconsumed byte.
rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
rx_busy  output  1  high from accepted start edge until return to IDLE.
frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
overrun  output  1  one-cycle pulse when a byte completes while rx_valid=1 and rx_ready=0.

Behaviour:
- Reset (rst=0), effective immediately, including mid-frame:
  - rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0.
  - FSM=IDLE, both synchronizer flops=1, all counters=0.
- Synchronizer: 2 flops on rx produce rx_s. Edge detection and sampling use rx_s only.
- Tick generator: DIV = round(CLK_FREQ/(BAUD*16)), minimum 1. It emits a 1-cycle tick every DIV clocks. A synchronous clear restarts it at the start edge so sample phase aligns to the frame.
- Sample counter s (0..15) advances on each tick. The bit decision is the majority of rx_s at s=7,8,9, taken when s=9.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on rx_s=0, clear the tick generator, set s=0 and bit count=0, go to START. rx_busy goes 1 the following cycle.
  - START: at the s=9 decision:
    - majority 1: false start; go to IDLE with no flags raised.
    - majority 0: stay until s=15 tick, then go to DATA.
  - DATA: per bit, the decision at s=9 shifts into shift_reg[7] (right shift, LSB first). The s=15 tick ends the bit. After the 8th bit, go to STOP.
  - STOP, at the s=9 decision:
    - majority 1: byte good, handed to the output stage; go to IDLE.
    - majority 0: frame_err pulses, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: remain until rx_s=1 (handles break), then go to IDLE.
  - Returning to IDLE at mid-stop allows back-to-back frames with up to half a bit of tolerance.
- Output stage, evaluated on the cycle a good byte completes:
  - rx_valid=0: rx_data<=byte; rx_valid=1 on the next cycle. Latency is 1 clk after the stop decision.
  - rx_valid=1 and rx_ready=1 (same-cycle consume): load the new byte, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ready=0: overrun pulses, the new byte is dropped, and the old rx_data is held.
- Handshake: rx_valid falls the cycle after rx_valid && rx_ready. rx_data is stable while rx_valid=1.
- No parity support. Exactly 1 stop bit is checked.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - OVERSAMPLE=16 and the sample indices 7/8/9/15;
  - a function computing DIV from CLK_FREQ/BAUD with rounding and a minimum of 1.
- One sub-module: uart_os_tick_gen. It is a divider with synchronous clear, tick output, and the same clk/rst.

Test Plan:
All tests use CLK_FREQ=1600000 and BAUD=10000, so DIV=10 and one bit is 160 clk.
- Byte 0xA5 sent 8N1, rx_ready=1 → rx_valid pulses once with rx_data=0xA5. No frame_err, no overrun. rx_busy drops at mid-stop.
- rx low for 60 clk, then high → no rx_valid, no frame_err, FSM back to IDLE, rx_busy=0.
- Byte 0x3C with the stop bit driven low, rx then held low for 500 clk → single frame_err pulse, no rx_valid. No new frame starts until rx returns high; a following 0x55 is then received correctly.
- Bytes 0x11 then 0x22 back-to-back with rx_ready=0 → rx_valid=1 with 0x11 and an overrun pulse at the second stop decision. rx_data still 0x11; after rx_ready=1 for one cycle, rx_valid=0.
- Byte 0x81 with a 1-clk glitch to 0 at sample 8 of bit 0 → majority vote still yields 0x81.
- rst driven 0 mid-DATA of 0xF0 → all outputs 0 immediately. After release, a fresh 0x0F is received with rx_data=0x0F.
